// File: rtl/irq_event_source.sv
// irq_event_source
// Partition-side interrupt generator. Each vector turns single-cycle event
// pulses into one rising edge on irq_req. Events that arrive while a request
// is outstanding, or while the vector is disabled, are coalesced into a
// saturating pending count and reported through last_cnt when the next
// request issues. If no ACK arrives within TIMEOUT cycles, the request is
// dropped and a sticky timeout flag is raised.
//
// Per-vector FSM:
//   state  | meaning
//   IDLE   | no request outstanding; issues as soon as enabled with events pending
//   WAIT   | irq_req held high until ACK or timeout
module irq_event_source #(
    parameter int IRQ_NUM = 16,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [IRQ_NUM-1:0]       ev_pulse,
    input  logic [IRQ_NUM-1:0]       irq_en,
    output logic [IRQ_NUM-1:0]       irq_req,
    input  logic [IRQ_NUM-1:0]       irq_ack,
    input  logic [IRQ_NUM-1:0]       clr_timeout,
    output logic [IRQ_NUM-1:0]       busy,
    output logic [IRQ_NUM-1:0]       timeout_flag,
    output logic [IRQ_NUM*CNT_W-1:0] last_cnt
);

    // Timer runs 0 .. TIMEOUT-1 while a request is outstanding.
    localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int               TMO_LAST = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMO_LAST);
    localparam bit               TMO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < IRQ_NUM; gi++) begin : g_vec
            state_t           r_state;
            state_t           w_state_nxt;
            logic [CNT_W-1:0] r_pend;
            logic [CNT_W-1:0] w_pend_sat;
            logic [CNT_W-1:0] r_last;
            logic [TMR_W-1:0] r_timer;
            logic             r_tmo_flag;
            logic             w_start;
            logic             w_ack;
            logic             w_tmo_hit;
            logic             w_req;

            // Pending count plus this cycle's event, clamped instead of wrapping
            always_comb begin
                w_pend_sat = r_pend;
                if (ev_pulse[gi] && (r_pend != CNT_MAX)) begin
                    w_pend_sat = r_pend + CNT_W'(1);
                end
            end

            // A same-cycle event counts as pending so the request goes out with 1-cycle latency
            assign w_start   = (r_state == S_IDLE) && irq_en[gi] &&
                               ((r_pend != '0) || ev_pulse[gi]);
            // ACK only matters while a request is outstanding; in IDLE it is spurious
            assign w_ack     = (r_state == S_WAIT) && irq_ack[gi];
            // ACK wins over a coincident timeout
            assign w_tmo_hit = TMO_EN && (r_state == S_WAIT) &&
                               (r_timer == TMR_LAST) && !irq_ack[gi];

            // State register
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_state <= S_IDLE;
                end else begin
                    r_state <= w_state_nxt;
                end
            end

            // Next-state logic; WAIT always returns through IDLE so irq_req sees a low cycle
            always_comb begin
                w_state_nxt = r_state;
                case (r_state)
                    S_IDLE: if (w_start) w_state_nxt = S_WAIT;
                    S_WAIT: if (w_ack || w_tmo_hit) w_state_nxt = S_IDLE;
                    default: w_state_nxt = S_IDLE;
                endcase
            end

            // Outputs decoded straight from the state flop, so they are registered
            always_comb begin
                w_req = (r_state == S_WAIT);
            end

            assign irq_req[gi] = w_req;
            assign busy[gi]    = w_req;

            // Pending events: cleared when handed to a new request, otherwise accumulate
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_pend <= '0;
                end else if (w_start) begin
                    r_pend <= '0;
                end else begin
                    r_pend <= w_pend_sat;
                end
            end

            // Snapshot of the events covered by the request being issued
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_last <= '0;
                end else if (w_start) begin
                    r_last <= w_pend_sat;
                end
            end

            // ACK timer: restarted on issue, advances only while waiting
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_timer <= '0;
                end else if (w_start) begin
                    r_timer <= '0;
                end else if (TMO_EN && (r_state == S_WAIT)) begin
                    r_timer <= r_timer + TMR_W'(1);
                end
            end

            // Sticky timeout flag; a new timeout beats a coincident clear
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_tmo_flag <= 1'b0;
                end else if (w_tmo_hit) begin
                    r_tmo_flag <= 1'b1;
                end else if (clr_timeout[gi]) begin
                    r_tmo_flag <= 1'b0;
                end
            end

            assign timeout_flag[gi]             = r_tmo_flag;
            assign last_cnt[gi*CNT_W +: CNT_W]  = r_last;
        end
    endgenerate

endmodule

// File: tb/tb_irq_event_source.sv
// Self-checking bench for irq_event_source (IRQ_NUM=16, CNT_W=8, TIMEOUT=16).
// Directed scenarios check against hand-derived constants; the random phase
// checks every cycle against a per-vector reference model built from the
// behavioural rules (saturating counts, request age in cycles).
module tb_irq_event_source;

    localparam int N    = 16;
    localparam int CW   = 8;
    localparam int TMO  = 16;
    localparam int MAXC = 255;

    logic              clk = 1'b0;
    logic              resetn;
    logic [N-1:0]      ev_pulse;
    logic [N-1:0]      irq_en;
    logic [N-1:0]      irq_req;
    logic [N-1:0]      irq_ack;
    logic [N-1:0]      clr_timeout;
    logic [N-1:0]      busy;
    logic [N-1:0]      timeout_flag;
    logic [N*CW-1:0]   last_cnt;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    int m_pend [N];
    int m_age  [N];
    int m_last [N];
    bit m_busy [N];
    bit m_flag [N];

    irq_event_source #(.IRQ_NUM(N), .CNT_W(CW), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ev_pulse     (ev_pulse),
        .irq_en       (irq_en),
        .irq_req      (irq_req),
        .irq_ack      (irq_ack),
        .clr_timeout  (clr_timeout),
        .busy         (busy),
        .timeout_flag (timeout_flag),
        .last_cnt     (last_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int sat(input int x);
        return (x > MAXC) ? MAXC : x;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_update();
        for (int i = 0; i < N; i++) begin
            int  ev;
            bit  set_flag;
            ev = ev_pulse[i] ? 1 : 0;
            set_flag = 1'b0;
            if (!resetn) begin
                m_pend[i] = 0; m_age[i] = 0; m_last[i] = 0;
                m_busy[i] = 1'b0; m_flag[i] = 1'b0;
            end else begin
                if (!m_busy[i]) begin
                    if (irq_en[i] && (m_pend[i] + ev > 0)) begin
                        m_last[i] = sat(m_pend[i] + ev);
                        m_pend[i] = 0;
                        m_busy[i] = 1'b1;
                        m_age[i]  = 1;
                    end else begin
                        m_pend[i] = sat(m_pend[i] + ev);
                    end
                end else begin
                    m_pend[i] = sat(m_pend[i] + ev);
                    if (irq_ack[i]) begin
                        m_busy[i] = 1'b0;
                    end else if (m_age[i] == TMO) begin
                        m_busy[i] = 1'b0;
                        set_flag  = 1'b1;
                    end else begin
                        m_age[i]++;
                    end
                end
                if (set_flag) m_flag[i] = 1'b1;
                else if (clr_timeout[i]) m_flag[i] = 1'b0;
            end
        end
    endtask

    function automatic logic [N-1:0] exp_req();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_busy[i];
        return r;
    endfunction

    function automatic logic [N-1:0] exp_flag();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_flag[i];
        return r;
    endfunction

    function automatic logic [N*CW-1:0] exp_last();
        logic [N*CW-1:0] r;
        for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'(m_last[i]);
        return r;
    endfunction

    // One clock: model follows the applied inputs, pulses are cleared afterwards
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        ev_pulse    = '0;
        irq_ack     = '0;
        clr_timeout = '0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        irq_en = '1;
        step();
        step();
        vectors++;
        if (irq_req !== '0 || busy !== '0) begin
            miscompares++;
            $display("FAIL reset_req: irq_req=%h busy=%h expected 0", irq_req, busy);
        end
        vectors++;
        if (timeout_flag !== '0 || last_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_state: flag=%h last_cnt=%h expected 0", timeout_flag, last_cnt);
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_single_event();
        ev_pulse[0] = 1'b1;
        step();
        vectors++;
        if (irq_req !== 16'h0001 || busy !== 16'h0001) begin
            miscompares++;
            $display("FAIL single_issue: irq_req=%h busy=%h expected 0001", irq_req, busy);
        end
        vectors++;
        if (last_cnt[0 +: CW] !== 8'd1) begin
            miscompares++;
            $display("FAIL single_last: last_cnt[0]=%0d expected 1", last_cnt[0 +: CW]);
        end
        repeat (3) step();
        irq_ack[0] = 1'b1;
        step();
        vectors++;
        if (irq_req !== 16'h0000) begin
            miscompares++;
            $display("FAIL single_ack: irq_req=%h expected 0000", irq_req);
        end
    endtask

    task automatic test_coalesce();
        ev_pulse[3] = 1'b1;
        step();
        repeat (3) begin
            ev_pulse[3] = 1'b1;
            step();
        end
        irq_ack[3] = 1'b1;
        step();
        vectors++;
        if (irq_req[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL coalesce_low: irq_req[3]=%b expected 0", irq_req[3]);
        end
        step();
        vectors++;
        if (irq_req[3] !== 1'b1 || last_cnt[3*CW +: CW] !== 8'd3) begin
            miscompares++;
            $display("FAIL coalesce_reissue: irq_req[3]=%b last_cnt[3]=%0d expected 1/3",
                     irq_req[3], last_cnt[3*CW +: CW]);
        end
        irq_ack[3] = 1'b1;
        step();
        step();
        vectors++;
        if (irq_req[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL coalesce_drained: irq_req[3]=%b expected 0", irq_req[3]);
        end
    endtask

    task automatic test_saturation();
        irq_en[1] = 1'b0;
        repeat (300) begin
            ev_pulse[1] = 1'b1;
            step();
        end
        vectors++;
        if (irq_req[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_masked: irq_req[1]=%b expected 0", irq_req[1]);
        end
        irq_en[1] = 1'b1;
        step();
        vectors++;
        if (irq_req[1] !== 1'b1 || last_cnt[1*CW +: CW] !== 8'd255) begin
            miscompares++;
            $display("FAIL sat_issue: irq_req[1]=%b last_cnt[1]=%0d expected 1/255",
                     irq_req[1], last_cnt[1*CW +: CW]);
        end
        irq_ack[1] = 1'b1;
        step();
        step();
        vectors++;
        if (irq_req[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_single: irq_req[1]=%b expected 0", irq_req[1]);
        end
    endtask

    task automatic test_timeout();
        int hi;
        ev_pulse[2] = 1'b1;
        step();
        hi = 0;
        for (int k = 0; k < 40 && irq_req[2]; k++) begin
            hi++;
            step();
        end
        vectors++;
        if (hi !== TMO) begin
            miscompares++;
            $display("FAIL timeout_len: high_cycles=%0d expected %0d", hi, TMO);
        end
        vectors++;
        if (timeout_flag[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_flag: flag[2]=%b expected 1", timeout_flag[2]);
        end
        clr_timeout[2] = 1'b1;
        step();
        vectors++;
        if (timeout_flag[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clr: flag[2]=%b expected 0", timeout_flag[2]);
        end
        ev_pulse[2] = 1'b1;
        step();
        repeat (TMO - 1) step();
        vectors++;
        if (irq_req[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_hold: irq_req[2]=%b expected 1", irq_req[2]);
        end
        clr_timeout[2] = 1'b1;
        step();
        vectors++;
        if (irq_req[2] !== 1'b0 || timeout_flag[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_set_wins: irq_req[2]=%b flag[2]=%b expected 0/1",
                     irq_req[2], timeout_flag[2]);
        end
    endtask

    task automatic test_ack_race();
        ev_pulse[4] = 1'b1;
        step();
        repeat (TMO - 1) step();
        irq_ack[4] = 1'b1;
        step();
        vectors++;
        if (irq_req[4] !== 1'b0 || timeout_flag[4] !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_race: irq_req[4]=%b flag[4]=%b expected 0/0",
                     irq_req[4], timeout_flag[4]);
        end
        irq_ack[4] = 1'b1;
        step();
        step();
        vectors++;
        if (irq_req[4] !== 1'b0 || timeout_flag[4] !== 1'b0 || last_cnt[4*CW +: CW] !== 8'd1) begin
            miscompares++;
            $display("FAIL spurious_ack: irq_req[4]=%b flag[4]=%b last_cnt[4]=%0d expected 0/0/1",
                     irq_req[4], timeout_flag[4], last_cnt[4*CW +: CW]);
        end
    endtask

    task automatic test_reset_mid_wait();
        ev_pulse = 16'h0021;
        step();
        vectors++;
        if (irq_req !== 16'h0021) begin
            miscompares++;
            $display("FAIL rst_setup: irq_req=%h expected 0021", irq_req);
        end
        ev_pulse = 16'h0021;
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        vectors++;
        if (irq_req !== '0 || busy !== '0 || timeout_flag !== '0 || last_cnt !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_wait: irq_req=%h busy=%h flag=%h last_cnt=%h expected 0",
                     irq_req, busy, timeout_flag, last_cnt);
        end
        step();
        irq_ack = 16'h0021;
        step();
        step();
        vectors++;
        if (irq_req !== '0 || last_cnt !== '0) begin
            miscompares++;
            $display("FAIL rst_no_reissue: irq_req=%h last_cnt=%h expected 0", irq_req, last_cnt);
        end
    endtask

    task automatic test_random();
        irq_en = '1;
        for (int c = 0; c < 3000; c++) begin
            resetn = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < N; i++) begin
                ev_pulse[i]    = ($urandom_range(0, 5) == 0);
                clr_timeout[i] = ($urandom_range(0, 15) == 0);
                if (m_busy[i]) irq_ack[i] = ($urandom_range(0, 7) == 0);
                else           irq_ack[i] = ($urandom_range(0, 31) == 0);
                if ($urandom_range(0, 15) == 0) irq_en[i] = ~irq_en[i];
            end
            step();
            vectors++;
            if (irq_req !== exp_req() || busy !== exp_req()) begin
                miscompares++;
                $display("FAIL rand_req c=%0d: irq_req=%h busy=%h expected %h",
                         c, irq_req, busy, exp_req());
            end
            vectors++;
            if (timeout_flag !== exp_flag()) begin
                miscompares++;
                $display("FAIL rand_flag c=%0d: flag=%h expected %h", c, timeout_flag, exp_flag());
            end
            vectors++;
            if (last_cnt !== exp_last()) begin
                miscompares++;
                $display("FAIL rand_last c=%0d: last_cnt=%h expected %h", c, last_cnt, exp_last());
            end
        end
        resetn = 1'b1;
    endtask

    initial begin
        resetn      = 1'b0;
        ev_pulse    = '0;
        irq_en      = '0;
        irq_ack     = '0;
        clr_timeout = '0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_age[i] = 0; m_last[i] = 0;
            m_busy[i] = 1'b0; m_flag[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_single_event();
        test_coalesce();
        test_saturation();
        test_timeout();
        test_ack_race();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
